pc11_tape_ctrl: RTL and testbench

//  PC11-style register front end and command sequencer for the SD tape emulator.

---
 rtl/pc11_tape_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pc11_tape_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc11_tape_ctrl.sv
// PC11-style paper-tape register front end and command sequencer for the SD tape emulator.
// Turns PRS/PRB/PPS/PPB accesses into one-cycle engine strobes and auto-flushes idle punch blocks.
module pc11_tape_ctrl #(
    parameter int SYS_FRQ  = 27_000_000,
    parameter int FLUSH_MS = 500
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [1:0]  i_reg_sel,
    input  logic        i_reg_wr,
    input  logic        i_reg_rd,
    input  logic [15:0] i_reg_wdata,
    output logic [15:0] o_reg_rdata,
    output logic        o_tape_read,
    output logic        o_tape_punch,
    output logic        o_tape_clear_done,
    output logic        o_tape_flush,
    output logic [7:0]  o_tape_punch_data,
    input  logic        i_tape_ready,
    input  logic        i_tape_read_done,
    input  logic [7:0]  i_tape_read_data,
    input  logic [3:0]  i_sd_error,
    output logic        o_ptr_irq,
    output logic        o_ptp_irq
);

    localparam int FLUSH_CYC = (SYS_FRQ / 1000) * FLUSH_MS;
    localparam int TMR_W     = $clog2(FLUSH_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FLUSH_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(FLUSH_CYC);

    localparam logic [1:0] SEL_PRS = 2'd0;
    localparam logic [1:0] SEL_PRB = 2'd1;
    localparam logic [1:0] SEL_PPS = 2'd2;
    localparam logic [1:0] SEL_PPB = 2'd3;

    typedef enum logic [2:0] {
        C_IDLE,
        C_RD_ISSUE,
        C_RD_WAIT,
        C_PUN_ISSUE,
        C_PUN_WAIT,
        C_CLR_ISSUE,
        C_FL_ISSUE,
        C_FL_WAIT
    } cmd_state_t;

    cmd_state_t state, next_state;

    logic             ie_r, ie_p;
    logic             rd_pend, clr_pend, pun_pend, fl_pend;
    logic             dirty;
    logic [TMR_W-1:0] flush_tmr;
    logic [7:0]       punch_data;
    logic [1:0]       wait_cnt;
    logic             wait_seen_low;

    // Bus decode
    logic wr_prs, wr_pps, wr_ppb, rd_prb;
    assign wr_prs = i_reg_wr & (i_reg_sel == SEL_PRS);
    assign wr_pps = i_reg_wr & (i_reg_sel == SEL_PPS);
    assign wr_ppb = i_reg_wr & (i_reg_sel == SEL_PPB);
    assign rd_prb = i_reg_rd & (i_reg_sel == SEL_PRB);

    logic unused_wdata;
    assign unused_wdata = &{1'b0, i_reg_wdata[15:8]};

    // Status terms
    logic sd_err, in_rd, in_pun, in_wait, busy, rd_done, punch_rdy;
    assign sd_err    = |i_sd_error;
    assign in_rd     = (state == C_RD_ISSUE) || (state == C_RD_WAIT);
    assign in_pun    = (state == C_PUN_ISSUE) || (state == C_PUN_WAIT);
    assign in_wait   = (state == C_RD_WAIT) || (state == C_PUN_WAIT) || (state == C_FL_WAIT);
    assign busy      = rd_pend | in_rd;
    assign rd_done   = i_tape_read_done & ~clr_pend;
    assign punch_rdy = ~pun_pend & ~in_pun & i_tape_ready;

    logic [15:0] prs_val, pps_val;
    assign prs_val = {sd_err, 3'b000, busy, 3'b000, rd_done, ie_r, 6'b000000};
    assign pps_val = {sd_err, 7'b0000000, punch_rdy, ie_p, 6'b000000};

    always_comb begin
        // NOTE: a default ahead of the case keeps every path assigned, so no latch is inferred.
        o_reg_rdata = 16'h0000;
        unique case (i_reg_sel)
            SEL_PRS: o_reg_rdata = prs_val;
            SEL_PRB: o_reg_rdata = {8'h00, i_tape_read_data};
            SEL_PPS: o_reg_rdata = pps_val;
            SEL_PPB: o_reg_rdata = {8'h00, punch_data};
        endcase
    end

    assign o_ptr_irq = ie_r & (rd_done | sd_err);
    assign o_ptp_irq = ie_p & (punch_rdy | sd_err);

    // Strobes decode straight from the state flop so async reset kills them at once
    assign o_tape_read       = (state == C_RD_ISSUE);
    assign o_tape_punch      = (state == C_PUN_ISSUE);
    assign o_tape_clear_done = (state == C_CLR_ISSUE);
    assign o_tape_flush      = (state == C_FL_ISSUE);
    assign o_tape_punch_data = punch_data;

    // Engine handshake: either a full ready low->high cycle, or four quiet cycles (strobe lost)
    logic wait_done;
    assign wait_done = i_tape_ready & (wait_seen_low | (wait_cnt == 2'd3));

    always_comb begin
        next_state = state;
        unique case (state)
            C_IDLE: begin
                if (i_tape_ready) begin
                    if (rd_pend)       next_state = C_RD_ISSUE;
                    else if (clr_pend) next_state = C_CLR_ISSUE;
                    else if (pun_pend) next_state = C_PUN_ISSUE;
                    else if (fl_pend)  next_state = C_FL_ISSUE;
                end
            end
            C_RD_ISSUE:  next_state = C_RD_WAIT;
            C_PUN_ISSUE: next_state = C_PUN_WAIT;
            C_CLR_ISSUE: next_state = C_IDLE;
            C_FL_ISSUE:  next_state = C_FL_WAIT;
            C_RD_WAIT, C_PUN_WAIT, C_FL_WAIT: begin
                if (wait_done) next_state = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: non-blocking assignments so every flop samples the values from before the edge.
        if (!i_reset_n) begin
            state         <= C_IDLE;
            wait_cnt      <= 2'd0;
            wait_seen_low <= 1'b0;
        end else begin
            state <= next_state;
            if (!in_wait) begin
                wait_cnt      <= 2'd0;
                wait_seen_low <= 1'b0;
            end else if (!i_tape_ready) begin
                wait_seen_low <= 1'b1;
            end else if (!wait_seen_low) begin
                wait_cnt <= wait_cnt + 2'd1;
            end
        end
    end

    // Pending work: a new request in the same cycle as its issue wins over the clear
    logic go_set, tmr_hit, fl_set;
    assign go_set  = wr_prs & i_reg_wdata[0] & ~busy;
    assign tmr_hit = dirty & (state == C_IDLE) & (flush_tmr == TMR_LAST);
    assign fl_set  = (wr_pps & i_reg_wdata[0]) | tmr_hit;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ie_r       <= 1'b0;
            ie_p       <= 1'b0;
            rd_pend    <= 1'b0;
            clr_pend   <= 1'b0;
            pun_pend   <= 1'b0;
            fl_pend    <= 1'b0;
            punch_data <= 8'h00;
        end else begin
            if (wr_prs) ie_r <= i_reg_wdata[6];
            if (wr_pps) ie_p <= i_reg_wdata[6];
            if (wr_ppb) punch_data <= i_reg_wdata[7:0];
            rd_pend  <= go_set | (rd_pend  & (state != C_RD_ISSUE));
            clr_pend <= rd_prb | (clr_pend & (state != C_CLR_ISSUE));
            pun_pend <= wr_ppb | (pun_pend & (state != C_PUN_ISSUE));
            fl_pend  <= fl_set | (fl_pend  & (state != C_FL_ISSUE));
        end
    end

    // Idle-punch timer: runs only while a block is dirty and the sequencer sits idle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dirty     <= 1'b0;
            flush_tmr <= '0;
        end else if (state == C_PUN_ISSUE) begin
            dirty     <= 1'b1;
            flush_tmr <= '0;
        end else if (state == C_FL_ISSUE) begin
            dirty     <= 1'b0;
            flush_tmr <= '0;
        end else if (dirty && (state == C_IDLE) && (flush_tmr != TMR_END)) begin
            flush_tmr <= flush_tmr + TMR_W'(1);
        end
    end

endmodule

// File: tb/tb_pc11_tape_ctrl.sv
// Directed bench for pc11_tape_ctrl with a small tape-engine model that drops ready for
// three cycles per accepted strobe and logs every strobe it sees.
module tb_pc11_tape_ctrl;

    localparam int SYS_FRQ  = 100_000;
    localparam int FLUSH_MS = 1;          // FLUSH_CYC = 100
    localparam int S_READ  = 0;
    localparam int S_PUNCH = 1;
    localparam int S_CLEAR = 2;
    localparam int S_FLUSH = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  reg_sel = 2'd0;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [15:0] reg_wdata = 16'h0000;
    logic [15:0] reg_rdata;
    logic        tape_read, tape_punch, tape_clear_done, tape_flush;
    logic [7:0]  tape_punch_data;
    logic        tape_ready = 1'b0;
    logic        tape_read_done = 1'b0;
    logic [7:0]  tape_read_data = 8'h00;
    logic [3:0]  sd_error = 4'h0;
    logic        ptr_irq, ptp_irq;

    int n_vec = 0;
    int n_bad = 0;

    pc11_tape_ctrl #(.SYS_FRQ(SYS_FRQ), .FLUSH_MS(FLUSH_MS)) dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n),
        .i_reg_sel         (reg_sel),
        .i_reg_wr          (reg_wr),
        .i_reg_rd          (reg_rd),
        .i_reg_wdata       (reg_wdata),
        .o_reg_rdata       (reg_rdata),
        .o_tape_read       (tape_read),
        .o_tape_punch      (tape_punch),
        .o_tape_clear_done (tape_clear_done),
        .o_tape_flush      (tape_flush),
        .o_tape_punch_data (tape_punch_data),
        .i_tape_ready      (tape_ready),
        .i_tape_read_done  (tape_read_done),
        .i_tape_read_data  (tape_read_data),
        .i_sd_error        (sd_error),
        .o_ptr_irq         (ptr_irq),
        .o_ptp_irq         (ptp_irq)
    );

    always #5 clk = ~clk;

    // Tape engine model: acts 1 time unit after each rising edge
    bit         card_present = 1'b1;
    bit         ignore_strobes = 1'b0;
    int         busy_cnt = 0;
    bit         busy_read = 1'b0;
    int         cyc = 0;
    int         read_cnt = 0, punch_cnt = 0, clear_cnt = 0, flush_cnt = 0;
    int         read_cyc = 0, punch_cyc = 0, flush_cyc = 0;
    logic [7:0] punch_byte = 8'h00;
    int         overlap_err = 0, long_err = 0;
    bit         prev_rd = 0, prev_pu = 0, prev_cl = 0, prev_fl = 0;

    always @(posedge clk) begin
        int nstb;
        #1;
        cyc++;
        nstb = int'(tape_read) + int'(tape_punch) + int'(tape_clear_done) + int'(tape_flush);
        if (nstb > 1) overlap_err++;
        if ((tape_read && prev_rd) || (tape_punch && prev_pu) ||
            (tape_clear_done && prev_cl) || (tape_flush && prev_fl)) long_err++;
        prev_rd = tape_read;
        prev_pu = tape_punch;
        prev_cl = tape_clear_done;
        prev_fl = tape_flush;
        if (tape_read)  begin read_cnt++;  read_cyc = cyc; end
        if (tape_punch) begin punch_cnt++; punch_cyc = cyc; punch_byte = tape_punch_data; end
        if (tape_flush) begin flush_cnt++; flush_cyc = cyc; end
        if (tape_clear_done) begin clear_cnt++; tape_read_done = 1'b0; end
        if (!card_present) begin
            tape_ready = 1'b0;
            busy_cnt   = 0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                tape_ready = 1'b1;
                if (busy_read) begin
                    tape_read_done = 1'b1;
                    tape_read_data = 8'h5A;
                end
            end
        end else begin
            tape_ready = 1'b1;
            if ((tape_read || tape_punch || tape_flush) && !ignore_strobes) begin
                tape_ready = 1'b0;
                busy_cnt   = 3;
                busy_read  = tape_read;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic peek(input logic [1:0] sel, output logic [15:0] data);
        reg_sel = sel;
        #1;
        data = reg_rdata;
    endtask

    task automatic bus_write(input logic [1:0] sel, input logic [15:0] data);
        @(negedge clk);
        reg_sel   = sel;
        reg_wdata = data;
        reg_wr    = 1'b1;
        @(negedge clk);
        reg_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] sel, output logic [15:0] data);
        @(negedge clk);
        reg_sel = sel;
        reg_rd  = 1'b1;
        #1;
        data = reg_rdata;
        @(negedge clk);
        reg_rd  = 1'b0;
    endtask

    task automatic wait_strobe(input string tag, input int which, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            case (which)
                S_READ:  seen = tape_read;
                S_PUNCH: seen = tape_punch;
                S_CLEAR: seen = tape_clear_done;
                default: seen = tape_flush;
            endcase
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_reg(input string tag, input logic [1:0] sel, input logic [15:0] mask,
                            input logic [15:0] value, input int max_cyc);
        logic [15:0] rv;
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max_cyc && !hit; i++) begin
            @(negedge clk);
            peek(sel, rv);
            hit = ((rv & mask) == value);
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rv;
        int base;

        // 1. Reset state
        repeat (3) @(negedge clk);
        check("rst_strobes", {tape_read, tape_punch, tape_clear_done, tape_flush}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("outs_after_rst", {tape_read, tape_punch, tape_clear_done, tape_flush,
                                 ptr_irq, ptp_irq, tape_punch_data}, 14'h0);
        peek(2'd0, rv); check("prs_reset", rv, 16'h0000);
        peek(2'd2, rv); check("pps_reset", rv, 16'h0080);

        // 2. Read cycle, done interrupt, PRB read and clear-done
        base = read_cnt;
        bus_write(2'd0, 16'h0041);
        peek(2'd0, rv); check("prs_busy_after_go", rv, 16'h0840);
        wait_strobe("rd_strobe_seen", S_READ, 10);
        wait_reg("rd_not_busy", 2'd0, 16'h0800, 16'h0000, 20);
        peek(2'd0, rv); check("prs_done", rv, 16'h00C0);
        check("ptr_irq_done", 32'(ptr_irq), 32'd1);
        check("rd_strobe_count", read_cnt - base, 1);
        base = clear_cnt;
        bus_read(2'd1, rv); check("prb_data", rv, 16'h005A);
        wait_strobe("clr_strobe_seen", S_CLEAR, 5);
        @(negedge clk);
        peek(2'd0, rv); check("prs_after_clear", rv, 16'h0040);
        check("ptr_irq_cleared", 32'(ptr_irq), 32'd0);
        check("clr_strobe_count", clear_cnt - base, 1);

        // 3. Punch held while engine not ready
        card_present = 1'b0;
        @(negedge clk);
        base = punch_cnt;
        bus_write(2'd3, 16'h0033);
        repeat (20) @(negedge clk);
        check("no_punch_not_ready", punch_cnt - base, 0);
        peek(2'd2, rv); check("pps_not_ready", rv, 16'h0000);
        check("punch_data_held", tape_punch_data, 8'h33);
        card_present = 1'b1;
        wait_strobe("pun_strobe_seen", S_PUNCH, 10);
        check("punch_data_issue", tape_punch_data, 8'h33);
        peek(2'd2, rv); check("pps_rdy0_issue", rv, 16'h0000);
        @(negedge clk);
        peek(2'd2, rv); check("pps_rdy0_wait", rv, 16'h0000);
        wait_reg("pps_rdy_back", 2'd2, 16'h0080, 16'h0080, 10);
        check("punch_count", punch_cnt - base, 1);
        check("punch_byte", punch_byte, 8'h33);

        // 4. Auto-flush after FLUSH_CYC idle cycles, restarted by a second punch
        do_reset(2);
        base = flush_cnt;
        bus_write(2'd3, 16'h0011);
        wait_strobe("fl_pun1_seen", S_PUNCH, 10);
        repeat (58) @(negedge clk);
        bus_write(2'd3, 16'h0012);
        check("no_flush_before_p2", flush_cnt - base, 0);
        wait_strobe("fl_pun2_seen", S_PUNCH, 10);
        wait_strobe("flush_seen", S_FLUSH, 150);
        // 1 issue + 3 wait (ready low) + 100 counted idle + 1 idle to issue
        check("flush_delay", flush_cyc - punch_cyc, 105);
        repeat (130) @(negedge clk);
        check("flush_once", flush_cnt - base, 1);

        // 5. GO and PPB both pending: read first, punch after read WAIT
        card_present = 1'b0;
        repeat (2) @(negedge clk);
        bus_write(2'd3, 16'h0077);
        bus_write(2'd0, 16'h0041);
        card_present = 1'b1;
        wait_strobe("prio_rd_first", S_READ, 10);
        check("prio_no_punch_yet", 32'(tape_punch), 32'd0);
        wait_strobe("prio_pun_seen", S_PUNCH, 20);
        check("prio_gap", punch_cyc - read_cyc, 5);
        check("prio_byte", punch_byte, 8'h77);

        // 6. Reset mid-operation
        repeat (6) @(negedge clk);
        bus_write(2'd0, 16'h0041);
        wait_strobe("rst_rd_seen", S_READ, 10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_wait_strobes", {tape_read, tape_punch, tape_clear_done, tape_flush}, 4'b0000);
        check("rst_wait_irqs", {ptr_irq, ptp_irq}, 2'b00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = read_cnt;
        repeat (10) @(negedge clk);
        check("rst_no_stray", read_cnt - base, 0);
        peek(2'd0, rv); check("rst_busy0", rv & 16'h0800, 16'h0000);
        bus_write(2'd0, 16'h0001);
        wait_strobe("rst_issue_seen", S_READ, 10);
        rst_n = 1'b0;
        #1;
        check("rst_issue_drop", 32'(tape_read), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 7. Lost strobe timeout, flush without dirty data, SD error bits
        ignore_strobes = 1'b1;
        bus_write(2'd0, 16'h0001);
        wait_strobe("lost_rd_seen", S_READ, 10);
        repeat (4) @(negedge clk);
        peek(2'd0, rv); check("lost_busy_4th", rv & 16'h0800, 16'h0800);
        @(negedge clk);
        peek(2'd0, rv); check("lost_busy_clear", rv & 16'h0800, 16'h0000);
        base = flush_cnt;
        bus_write(2'd2, 16'h0041);
        wait_strobe("clean_flush_seen", S_FLUSH, 10);
        check("clean_flush_count", flush_cnt - base, 1);
        peek(2'd2, rv); check("pps_ie_rdy", rv, 16'h00C0);
        check("ptp_irq_rdy", 32'(ptp_irq), 32'd1);
        @(negedge clk);
        sd_error = 4'h5;
        peek(2'd2, rv); check("pps_err", rv, 16'h80C0);
        peek(2'd0, rv); check("prs_err", rv & 16'h8840, 16'h8000);
        check("ptr_irq_ie0", 32'(ptr_irq), 32'd0);
        bus_write(2'd0, 16'h0040);
        peek(2'd0, rv); check("prs_err_ie", rv & 16'h8840, 16'h8040);
        check("ptr_irq_err", 32'(ptr_irq), 32'd1);
        sd_error = 4'h0;

        check("strobe_overlap", overlap_err, 0);
        check("strobe_width", long_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
